fft_stage_sequencer: RTL and testbench

Sequences all NUMSTAGES passes of the 32-point radix-2 FFT over the 4-bank RAM and the single 4-input PE, which runs two butterflies per cycle. Uses a constant-geometry, ping-pong schedule: each stage reads page p and writes page ~p, and the bank/address layout is conflict-free for both reads and writes. Drives the bank read/write addresses and enables, the PE input and output crossbar selects, and the twiddle ROM address. Sits between the top-level FFT FSM (start/done) and the RAM/PE datapath.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_stage_sequencer_if.sv | 32 +++
 rtl/fft_sched_delay.sv | 39 +++
 rtl/fft_stage_sequencer.sv | 133 +++++++++++++
 tb/tb_fft_stage_sequencer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT stage sequencer
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BANKS        = 4;
  localparam int FFT_ADDRSIZE = 3;

  typedef struct packed {
    logic [1:0]              bank;
    logic [FFT_ADDRSIZE-1:0] addr;
  } loc_t;

  // Load layout: bank {n4^n1, n0}, addr n[4:2]; keeps every stage's reads and writes conflict-free.
  function automatic loc_t sample_loc(input logic [4:0] n);
    loc_t l;
    l.bank = {n[4] ^ n[1], n[0]};
    l.addr = n[4:2];
    return l;
  endfunction

  // Twiddle index: counter with its low s bits cleared; naturally 0 once s >= FFT_ADDRSIZE.
  function automatic logic [FFT_ADDRSIZE-1:0] tw_mask(input logic [FFT_ADDRSIZE-1:0] c,
                                                      input logic [2:0]              s);
    logic [FFT_ADDRSIZE-1:0] ones;
    ones = '1;
    return c & (ones << s);
  endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// rtl/fft_stage_sequencer_if.sv - control/address bundle between sequencer and RAM/PE datapath
interface fft_stage_sequencer_if #(
  parameter int ADDRSIZE = 3
);
  logic                start;
  logic                busy;
  logic                done;
  logic [2:0]          stage_num;
  logic                rd_en;
  logic [ADDRSIZE:0]   rd_addr0;
  logic [ADDRSIZE:0]   rd_addr1;
  logic [ADDRSIZE:0]   rd_addr2;
  logic [ADDRSIZE:0]   rd_addr3;
  logic                rd_sel;
  logic [ADDRSIZE-1:0] tw_addr;
  logic                wr_en;
  logic [ADDRSIZE:0]   wr_addr;
  logic                wr_sel;
  logic                result_page;

  modport master (
    input  start,
    output busy, done, stage_num, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
           rd_sel, tw_addr, wr_en, wr_addr, wr_sel, result_page
  );

  modport slave (
    output start,
    input  busy, done, stage_num, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3,
           rd_sel, tw_addr, wr_en, wr_addr, wr_sel, result_page
  );
endinterface

// File: rtl/fft_sched_delay.sv
// rtl/fft_sched_delay.sv - valid/counter/page shift register aligning schedule to datapath latency
module fft_sched_delay #(
  parameter int DEPTH = 1,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [CW-1:0] in_c,
  input  logic          in_page,
  output logic          out_valid,
  output logic [CW-1:0] out_c,
  output logic          out_page
);

  localparam int W = CW + 2;

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_c     = in_c;
      assign out_page  = in_page;
    end else begin : g_sr
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          sr[0] <= {in_valid, in_c, in_page};
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign {out_valid, out_c, out_page} = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/fft_stage_sequencer.sv
// rtl/fft_stage_sequencer.sv - constant-geometry ping-pong schedule for the 32-point radix-2 FFT
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int ADDRSIZE   = FFT_ADDRSIZE,
  parameter int NUMSTAGES  = 5,
  parameter int NUMSAMPLES = 32,
  parameter int RD_LAT     = 1,
  parameter int PE_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_stage_sequencer_if.master bus
);

  localparam int                  DLY    = RD_LAT + PE_LAT;
  localparam logic [ADDRSIZE-1:0] C_LAST = ADDRSIZE'(NUMSAMPLES / BANKS - 1);
  localparam logic [2:0]          S_LAST = 3'(NUMSTAGES - 1);
  localparam logic [2:0]          D_LAST = 3'(DLY - 1);

  state_t              state_q, state_d;
  logic [ADDRSIZE-1:0] c_q, c_d;
  logic [2:0]          s_q, s_d;
  logic [2:0]          drn_q, drn_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      s_q     <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      s_q     <= s_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    s_d     = s_q;
    drn_d   = drn_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_ISSUE;
          c_d     = '0;
          s_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (c_q == C_LAST) begin
          state_d = ST_DRAIN;
          c_d     = '0;
          drn_d   = '0;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      // Next stage reads what this one writes, so wait for the last write to land.
      ST_DRAIN: begin
        if (drn_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            s_d     = s_q + 1'b1;
          end
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic                issue_v, busy;
  logic                pe_v, pe_p, wr_v, wr_p;
  logic [ADDRSIZE-1:0] pe_c, wr_c;
  logic                page;

  assign issue_v = (state_q == ST_ISSUE);
  assign busy    = issue_v || (state_q == ST_DRAIN);
  assign page    = s_q[0];

  fft_sched_delay #(.DEPTH(RD_LAT), .CW(ADDRSIZE)) u_rd_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue_v),
    .in_c      (c_q),
    .in_page   (page),
    .out_valid (pe_v),
    .out_c     (pe_c),
    .out_page  (pe_p)
  );

  fft_sched_delay #(.DEPTH(PE_LAT), .CW(ADDRSIZE)) u_pe_dly (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (pe_v),
    .in_c      (pe_c),
    .in_page   (pe_p),
    .out_valid (wr_v),
    .out_c     (wr_c),
    .out_page  (wr_p)
  );

  // Banks 2/3 swap the top address bit on odd counts so each cycle fetches pairs (i, i+16).
  assign bus.rd_en    = issue_v;
  assign bus.rd_addr0 = issue_v ? {page, c_q[0],        c_q[ADDRSIZE-1:1]} : '0;
  assign bus.rd_addr1 = issue_v ? {page, c_q[0],        c_q[ADDRSIZE-1:1]} : '0;
  assign bus.rd_addr2 = issue_v ? {page, ~c_q[0],       c_q[ADDRSIZE-1:1]} : '0;
  assign bus.rd_addr3 = issue_v ? {page, ~c_q[0],       c_q[ADDRSIZE-1:1]} : '0;

  assign bus.rd_sel  = pe_v & pe_c[0];
  assign bus.tw_addr = pe_v ? tw_mask(pe_c, s_q) : '0;

  assign bus.wr_en   = wr_v;
  assign bus.wr_addr = wr_v ? {~wr_p, wr_c} : '0;
  assign bus.wr_sel  = wr_v & wr_c[ADDRSIZE-1];

  assign bus.busy        = busy;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.stage_num   = busy ? s_q : '0;
  assign bus.result_page = 1'(NUMSTAGES % 2);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb/tb_fft_stage_sequencer.sv - self-checking bench for fft_stage_sequencer
module tb_fft_stage_sequencer;
  localparam int RD_LAT = 1;
  localparam int PE_LAT = 1;
  localparam int NST    = 5;
  localparam int NC     = 8;
  localparam int L      = NC + RD_LAT + PE_LAT;
  localparam int RUN    = NST * L;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.ADDRSIZE(3)) bus();

  fft_stage_sequencer #(.RD_LAT(RD_LAT), .PE_LAT(PE_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       busy, done;
    logic [2:0] stage;
    logic       rd_en;
    logic [3:0] ra0, ra1, ra2, ra3;
    logic       rd_sel;
    logic [2:0] tw;
    logic       wr_en;
    logic [3:0] wa;
    logic       wr_sel;
    logic       rp;
  } obs_t;

  typedef struct packed {
    logic       busy, done;
    logic [2:0] stage;
    logic       rd_en;
    logic [3:0] ra0, ra2;
    logic       rd_sel;
    logic [2:0] tw;
    logic       wr_en;
    logic [3:0] wa;
    logic       wr_sel;
  } tv_t;

  typedef struct {
    int  k;
    tv_t e;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   k = 0;
  obs_t snap [0:RUN+2];
  vec_t tab [12];

  function automatic int bank_of(int n);
    return ((((n >> 4) ^ (n >> 1)) & 1) << 1) | (n & 1);
  endfunction

  function automatic int addr_of(int n);
    return (n >> 2) & 7;
  endfunction

  // Stage butterflies pair positions (i, i+16) and write results to positions 2i, 2i+1.
  function automatic obs_t model(int kk);
    obs_t       e;
    int         s, j, p, c, b;
    int         qs [4];
    logic [3:0] a;
    e = '0;
    e.rp = 1'b1;
    if (kk == RUN + 1) begin
      e.done = 1'b1;
    end else if (kk >= 1 && kk <= RUN) begin
      s = (kk - 1) / L;
      j = (kk - 1) % L;
      p = s & 1;
      e.busy  = 1'b1;
      e.stage = 3'(s);
      if (j < NC) begin
        e.rd_en = 1'b1;
        qs[0] = 2*j; qs[1] = 2*j + 1; qs[2] = 2*j + 16; qs[3] = 2*j + 17;
        for (int i = 0; i < 4; i++) begin
          b = bank_of(qs[i]);
          a = 4'((p << 3) | addr_of(qs[i]));
          case (b)
            0: e.ra0 = a;
            1: e.ra1 = a;
            2: e.ra2 = a;
            default: e.ra3 = a;
          endcase
        end
      end
      c = j - RD_LAT;
      if (c >= 0 && c < NC) begin
        e.rd_sel = (bank_of(2*c) == 2);
        e.tw     = (s >= 3) ? 3'd0 : 3'((c >> s) << s);
      end
      c = j - RD_LAT - PE_LAT;
      if (c >= 0 && c < NC) begin
        e.wr_en  = 1'b1;
        e.wa     = 4'(((1 - p) << 3) | addr_of(4*c));
        e.wr_sel = (bank_of(4*c) == 2);
      end
    end
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = {bus.busy, bus.done, bus.stage_num, bus.rd_en, bus.rd_addr0, bus.rd_addr1,
         bus.rd_addr2, bus.rd_addr3, bus.rd_sel, bus.tw_addr, bus.wr_en, bus.wr_addr,
         bus.wr_sel, bus.result_page};
    return o;
  endfunction

  function automatic tv_t proj(obs_t o);
    return {o.busy, o.done, o.stage, o.rd_en, o.ra0, o.ra2, o.rd_sel, o.tw, o.wr_en, o.wa, o.wr_sel};
  endfunction

  task automatic check(string nm, obs_t exp);
    obs_t act;
    act = sample();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  task automatic chk_int(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic step(logic st);
    bus.start = st;
    @(posedge clk);
    if (k == 0)            k = st ? 1 : 0;
    else if (k == RUN + 1) k = 0;
    else                   k++;
    @(negedge clk);
    check("model", model(k));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("async_reset", model(0));
    k = 0;
    @(posedge clk);
    @(negedge clk);
    check("in_reset", model(0));
    rst_n = 1'b1;
    repeat (12) step(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w0, wt, dn, guard;

    //            k    busy_done_stage_rden_ra0_ra2_rdsel_tw_wren_wa_wrsel
    tab[0]  = '{1,  24'b1_0_000_1_0000_0100_0_000_0_0000_0};
    tab[1]  = '{4,  24'b1_0_000_1_0101_0001_0_010_1_1001_0};
    tab[2]  = '{8,  24'b1_0_000_1_0111_0011_0_110_1_1101_1};
    tab[3]  = '{10, 24'b1_0_000_0_0000_0000_0_000_1_1111_1};
    tab[4]  = '{11, 24'b1_0_001_1_1000_1100_0_000_0_0000_0};
    tab[5]  = '{14, 24'b1_0_001_1_1101_1001_0_010_1_0001_0};
    tab[6]  = '{15, 24'b1_0_001_1_1010_1110_1_010_1_0010_0};
    tab[7]  = '{26, 24'b1_0_010_1_0110_0010_0_100_1_1011_0};
    tab[8]  = '{35, 24'b1_0_011_1_1010_1110_1_000_1_0010_0};
    tab[9]  = '{50, 24'b1_0_100_0_0000_0000_0_000_1_1111_1};
    tab[10] = '{51, 24'b0_1_000_0_0000_0000_0_000_0_0000_0};
    tab[11] = '{52, 24'b0_0_000_0_0000_0000_0_000_0_0000_0};

    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", model(0));
    rst_n = 1'b1;

    step(1'b1);
    snap[1] = sample();
    for (int i = 2; i <= RUN + 2; i++) begin
      step(1'b0);
      snap[i] = sample();
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (proj(snap[tab[i].k]) !== tab[i].e) begin
        n_bad++;
        $display("FAIL table k=%0d actual=%h required=%h", tab[i].k, proj(snap[tab[i].k]), tab[i].e);
      end
    end
    w0 = 0;
    wt = 0;
    for (int i = 1; i <= L; i++)       w0 += int'(snap[i].wr_en);
    for (int i = 1; i <= RUN + 1; i++) wt += int'(snap[i].wr_en);
    chk_int("stage0_writes", w0, NC);
    chk_int("total_writes", wt, NST * NC);

    // start held high through the whole run, including the done cycle
    dn = 0;
    for (int i = 0; i < RUN + 1; i++) begin
      step(1'b1);
      if (bus.done) dn++;
    end
    step(1'b0);
    chk_int("held_start_done_pulses", dn, 1);

    // start on the done cycle is dropped; start on the next cycle is taken
    step(1'b1);
    repeat (RUN) step(1'b0);
    step(1'b1);
    step(1'b1);
    chk_int("restart_after_done_busy", int'(bus.busy), 1);
    guard = 0;
    while (k != 0 && guard < 200) begin
      step(1'b0);
      guard++;
    end
    chk_int("restart_run_ends", k, 0);

    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 3)) step(1'b0);
      step(1'b1);
      guard = 0;
      while (k != 0 && guard < 200) begin
        if (it == 2 && k == 2 * L + 3) do_reset();
        else step($urandom_range(0, 3) == 0);
        guard++;
      end
      chk_int("random_run_bounded", k, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
